pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, width of control field (memRead/memWrite/memToReg/regWrite class bits).
REQ-002 SHALL have parameter DATA_W, default 69, width of data payload (aluResult+rtData+wbAddr class fields).
REQ-003 SHALL have parameter BUBBLE_CTRL, default all-zero, control value presented whenever out_valid_o=0.
REQ-004 Port: clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid_i  input  1  upstream stage holds valid payload.
REQ-007 Port: in_ready_o  output  1  stage can accept payload this cycle.
REQ-008 Port: in_ctrl_i  input  CTRL_W  upstream control bits.
REQ-009 Port: in_data_i  input  DATA_W  upstream data bits.
REQ-010 Port: out_valid_o  output  1  output payload valid.
REQ-011 Port: out_ready_i  input  1  downstream accepts payload (0 = downstream stall).
REQ-012 Port: out_ctrl_o  output  CTRL_W  registered control bits.
REQ-013 Port: out_data_o  output  DATA_W  registered data bits.
REQ-014 Port: flush_i  input  1  discard all held and incoming payloads.
REQ-015 Port: occ_o  output  2  occupancy, 0..2.

Function
REQ-016 SHALL implement a two-entry skid buffer: main register (drives outputs) and skid register.
REQ-017 SHALL implement states EMPTY (occ 0), ONE (main valid), FULL (main+skid valid); occ_o equals state encoding 0/1/2.
REQ-018 in_ready_o SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready_i to in_ready_o.
REQ-019 Input transfer SHALL occur when in_valid_i=1 and in_ready_o=1; output transfer when out_valid_o=1 and out_ready_i=1.
REQ-020 Latency SHALL be exactly 1 cycle: payload accepted on edge N appears on outputs after edge N when stage was EMPTY, or ONE with simultaneous output transfer.
REQ-021 Transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (main reloaded); ONE+in, no out -> FULL (payload into skid); ONE+out, no in -> EMPTY; FULL+out -> ONE (skid moves to main); otherwise hold.
REQ-022 Sustained in_valid_i=1 and out_ready_i=1 SHALL give one transfer per cycle, no bubbles.
REQ-023 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated absent flush.
REQ-024 In FULL, in_valid_i SHALL be ignored (in_ready_o=0); upstream holds payload.
REQ-025 flush_i=1 SHALL, on next edge, force state EMPTY, in_ready_o=1, discard main, skid and any same-cycle input; flush has priority over all transfers.
REQ-026 out_ctrl_o SHALL equal BUBBLE_CTRL whenever out_valid_o=0; out_data_o SHALL hold its last value when invalid (don't-care to consumers).
REQ-027 Main and skid registers SHALL hold contents unchanged while no transfer and no flush occur (stall hold).
REQ-028 Outputs SHALL be driven only from registers, no combinational input-to-output paths.

Reset
REQ-029 rst_n_i=0 SHALL immediately, independent of clk_i, force state EMPTY, out_valid_o=0, in_ready_o=1, occ_o=0, out_ctrl_o=BUBBLE_CTRL, out_data_o=0, skid cleared.
REQ-030 Reset asserted mid-operation SHALL discard all held payloads; first transfer permitted on first rising edge after rst_n_i returns to 1.

Verification
REQ-031 Reset: drive rst_n_i=0 between edges with FULL state -> outputs immediately out_valid_o=0, occ_o=0, in_ready_o=1, out_ctrl_o=0.
REQ-032 Streaming: 8 payloads data=1..8, in_valid_i=1, out_ready_i=1 every cycle -> out_data_o 1..8 on consecutive cycles, occ_o=1 throughout.
REQ-033 Backpressure: stream 1..4, out_ready_i=0 after payload 1 appears -> payload 2 enters skid, occ_o=2, in_ready_o=0 next cycle; release out_ready_i -> outputs 1,2,3,4 in order, none lost.
REQ-034 Flush: FULL holding 5,6 with in_valid_i=1 data=7 and flush_i=1 -> next cycle out_valid_o=0, occ_o=0, out_ctrl_o=BUBBLE_CTRL; 5,6,7 never observed.
REQ-035 Bubble: in_ctrl_i=4'b1111 with in_valid_i=0 -> out_ctrl_o stays 4'b0000, out_valid_o=0.
REQ-036 Parameter sweep: CTRL_W=1/DATA_W=8 and CTRL_W=8/DATA_W=128 rerun REQ-032/033 with random out_ready_i -> scoreboard order match, zero loss.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream in_* channel, downstream out_* channel, flush, occupancy.
// No latency of its own; it only carries wires.
// Backpressure travels as out_ready_i into the stage and in_ready_o out of it.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic              flush_i;
  logic [1:0]        occ_o;

  // Stage side of the bundle.
  modport slave (
    input  in_valid_i, in_ctrl_i, in_data_i, out_ready_i, flush_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occ_o
  );

  // Environment side: drives the upstream payload and the downstream ready.
  modport master (
    output in_valid_i, in_ctrl_i, in_data_i, out_ready_i, flush_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occ_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with a flush input and a bubble control value.
// Latency is 1 cycle from input transfer to output. Throughput is one payload per cycle.
// in_ready_o is registered, so the skid entry absorbs the one payload already in flight when downstream stalls.
module pipe_stage_reg #(
  parameter int              CTRL_W      = 4,
  parameter int              DATA_W      = 69,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.in_valid_i & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready_i;

  // Next-state logic and payload routing. Flush overrides every transfer.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            main_ctrl_d = bus.in_ctrl_i;
            main_data_d = bus.in_data_i;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: begin
              main_ctrl_d = bus.in_ctrl_i;
              main_data_d = bus.in_data_i;
            end
            2'b10: begin
              state_d     = FULL;
              skid_ctrl_d = bus.in_ctrl_i;
              skid_data_d = bus.in_data_i;
            end
            2'b01:   state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          // in_ready_o is low here, so only the drain path matters.
          if (out_xfer) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // The output control register holds the bubble value whenever the stage is empty.
    // That keeps out_ctrl_o a pure flop output.
    if (state_d == EMPTY) begin
      main_ctrl_d = BUBBLE_CTRL;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State and payload registers. Reset discards everything and clears both entries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_ctrl_o  = main_ctrl_q;
  assign bus.out_data_o  = main_data_q;
  assign bus.occ_o       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, mid-operation reset, randomized run.
// Three parameterizations share one stimulus and are checked against a queue model.
// Downstream ready is randomized. Upstream holds its payload until the model accepts it.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_ready, s_flush;
  logic [7:0]   s_ctrl;
  logic [127:0] s_data;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(4), .DATA_W(69))  ifa ();
  pipe_stage_reg_if #(.CTRL_W(1), .DATA_W(8))   ifb ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) ifc ();

  assign ifa.in_valid_i = s_valid; assign ifa.out_ready_i = s_ready; assign ifa.flush_i = s_flush;
  assign ifa.in_ctrl_i  = s_ctrl[3:0]; assign ifa.in_data_i = s_data[68:0];
  assign ifb.in_valid_i = s_valid; assign ifb.out_ready_i = s_ready; assign ifb.flush_i = s_flush;
  assign ifb.in_ctrl_i  = s_ctrl[0:0]; assign ifb.in_data_i = s_data[7:0];
  assign ifc.in_valid_i = s_valid; assign ifc.out_ready_i = s_ready; assign ifc.flush_i = s_flush;
  assign ifc.in_ctrl_i  = s_ctrl; assign ifc.in_data_i = s_data;

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69))  dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa));
  pipe_stage_reg #(.CTRL_W(1), .DATA_W(8))   dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb));
  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128)) dut_c (.clk_i(clk), .rst_n_i(rst_n), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]   c;
    logic [127:0] d;
  } pay_t;
  pay_t mq[$];

  typedef struct {
    bit         v;
    logic [3:0] c;
    logic [7:0] d;
    bit         r;
    bit         f;
    bit         ev;
    logic [1:0] eo;
    bit         erdy;
    logic [3:0] ec;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a FIFO of capacity two. Ready reflects the occupancy before the edge.
  task automatic model_edge(output bit accepted);
    bit rdy;
    accepted = 1'b0;
    if (s_flush) begin
      mq.delete();
    end else begin
      rdy = (mq.size() < 2);
      if (mq.size() > 0 && s_ready) void'(mq.pop_front());
      if (s_valid && rdy) begin
        mq.push_back('{c: s_ctrl, d: s_data});
        accepted = 1'b1;
      end
    end
  endtask

  task automatic chk_inst(input string tag, input int cw, input int dw,
                          input logic v, input logic [1:0] o, input logic r,
                          input logic [7:0] c, input logic [127:0] d);
    logic [7:0]   cmask;
    logic [127:0] dmask;
    bit           ev;
    cmask = (8'(1) << cw) - 8'(1);
    dmask = (128'(1) << dw) - 128'(1);
    ev    = (mq.size() > 0);
    chk({tag, "_valid"}, 128'(v), 128'(ev));
    chk({tag, "_occ"},   128'(o), 128'(mq.size()));
    chk({tag, "_ready"}, 128'(r), 128'(mq.size() < 2));
    chk({tag, "_ctrl"},  128'(c), ev ? 128'(mq[0].c & cmask) : 128'(0));
    if (ev) chk({tag, "_data"}, d, mq[0].d & dmask);
  endtask

  task automatic check_model();
    chk_inst("a", 4, 69,  ifa.out_valid_o, ifa.occ_o, ifa.in_ready_o, 8'(ifa.out_ctrl_o), 128'(ifa.out_data_o));
    chk_inst("b", 1, 8,   ifb.out_valid_o, ifb.occ_o, ifb.in_ready_o, 8'(ifb.out_ctrl_o), 128'(ifb.out_data_o));
    chk_inst("c", 8, 128, ifc.out_valid_o, ifc.occ_o, ifc.in_ready_o, ifc.out_ctrl_o, ifc.out_data_o);
  endtask

  task automatic add(input bit v, input logic [3:0] c, input logic [7:0] d, input bit r, input bit f,
                     input bit ev, input logic [1:0] eo, input bit erdy, input logic [3:0] ec,
                     input logic [7:0] ed);
    tbl.push_back('{v: v, c: c, d: d, r: r, f: f, ev: ev, eo: eo, erdy: erdy, ec: ec, ed: ed});
  endtask

  task automatic step(output bit accepted);
    model_edge(accepted);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 128'(ifa.out_valid_o), 128'(0));
    chk({tag, "_occ"},   128'(ifa.occ_o),       128'(0));
    chk({tag, "_ready"}, 128'(ifa.in_ready_o),  128'(1));
    chk({tag, "_ctrl"},  128'(ifa.out_ctrl_o),  128'(0));
    chk({tag, "_data"},  128'(ifa.out_data_o),  128'(0));
    chk({tag, "_data_b"}, 128'(ifb.out_data_o), 128'(0));
    chk({tag, "_data_c"}, ifc.out_data_o,       128'(0));
  endtask

  initial begin
    bit acc;
    bit hold;
    s_valid = 0; s_ready = 0; s_flush = 0; s_ctrl = '0; s_data = '0;
    rst_n = 1'b0;
    #12;
    chk_reset_vals("rst_init");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming 1..8 with ctrl = low nibble of data.
    for (int i = 1; i <= 8; i++) add(1, 4'(i), 8'(i), 1, 0, 1, 2'd1, 1, 4'(i), 8'(i));
    add(0, 4'h0, 8'h0, 1, 0, 0, 2'd0, 1, 4'h0, 8'h0);
    // Backpressure: 2 goes to the skid entry, 3 waits upstream, then everything drains in order.
    add(1, 4'h1, 8'd1, 1, 0, 1, 2'd1, 1, 4'h1, 8'd1);
    add(1, 4'h2, 8'd2, 0, 0, 1, 2'd2, 0, 4'h1, 8'd1);
    add(1, 4'h3, 8'd3, 0, 0, 1, 2'd2, 0, 4'h1, 8'd1);
    add(1, 4'h3, 8'd3, 1, 0, 1, 2'd1, 1, 4'h2, 8'd2);
    add(1, 4'h3, 8'd3, 1, 0, 1, 2'd1, 1, 4'h3, 8'd3);
    add(1, 4'h4, 8'd4, 1, 0, 1, 2'd1, 1, 4'h4, 8'd4);
    add(0, 4'h0, 8'd0, 1, 0, 0, 2'd0, 1, 4'h0, 8'd0);
    // Flush a full stage together with a same-cycle input.
    add(1, 4'h5, 8'd5, 0, 0, 1, 2'd1, 1, 4'h5, 8'd5);
    add(1, 4'h6, 8'd6, 0, 0, 1, 2'd2, 0, 4'h5, 8'd5);
    add(1, 4'h7, 8'd7, 0, 1, 0, 2'd0, 1, 4'h0, 8'd0);
    add(0, 4'h7, 8'd7, 1, 0, 0, 2'd0, 1, 4'h0, 8'd0);
    // Bubble: control bits without valid never reach the output.
    add(0, 4'hF, 8'd9, 1, 0, 0, 2'd0, 1, 4'h0, 8'd0);
    add(0, 4'hF, 8'd9, 0, 0, 0, 2'd0, 1, 4'h0, 8'd0);

    foreach (tbl[i]) begin
      s_valid = tbl[i].v; s_ctrl = 8'(tbl[i].c); s_data = 128'(tbl[i].d);
      s_ready = tbl[i].r; s_flush = tbl[i].f;
      step(acc);
      chk($sformatf("vec%0d_valid", i), 128'(ifa.out_valid_o), 128'(tbl[i].ev));
      chk($sformatf("vec%0d_occ", i),   128'(ifa.occ_o),       128'(tbl[i].eo));
      chk($sformatf("vec%0d_ready", i), 128'(ifa.in_ready_o),  128'(tbl[i].erdy));
      chk($sformatf("vec%0d_ctrl", i),  128'(ifa.out_ctrl_o),  128'(tbl[i].ec));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 128'(ifa.out_data_o), 128'(tbl[i].ed));
      check_model();
    end

    // Fill the stage, then assert reset between clock edges.
    s_flush = 0; s_ready = 0; s_valid = 1;
    s_ctrl = 8'hA5; s_data = 128'h9;  step(acc);
    s_ctrl = 8'h5A; s_data = 128'hA;  step(acc);
    chk("pre_rst_occ", 128'(ifa.occ_o), 128'(2));
    #2 rst_n = 1'b0;
    mq.delete();
    #1;
    chk_reset_vals("rst_async");
    #1 rst_n = 1'b1;
    s_valid = 1; s_ready = 1; s_ctrl = 8'h3C; s_data = 128'hB;
    step(acc);
    chk("post_rst_first", 128'(ifa.out_data_o), 128'hB);
    check_model();

    // Randomized traffic across all three widths.
    hold = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_ctrl  = 8'($urandom);
        s_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      s_ready = (n < 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
      s_flush = ($urandom_range(0, 49) == 0);
      step(acc);
      hold = s_valid && !acc;
      check_model();
    end

    // Drain whatever is left.
    s_valid = 0; s_flush = 0; s_ready = 1;
    for (int n = 0; n < 3; n++) begin
      step(acc);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
